// File: rtl/tone_envelope_pkg.sv
// Shared state encoding and helpers for the tone envelope slice.
package tone_envelope_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ATTACK  = 3'd1,
      DECAY   = 3'd2,
      SUSTAIN = 3'd3,
      RELEASE = 3'd4
   } env_state_t;

   localparam int unsigned           ENV_BW_LVL  = 8;
   localparam logic [ENV_BW_LVL-1:0] ENV_LVL_MAX = '1;

   // A zero step would stall the envelope forever, so it behaves as 1.
   function automatic logic [3:0] eff_step(input logic [3:0] s);
      return (s == 4'd0) ? 4'd1 : s;
   endfunction

endpackage

// File: rtl/tone_envelope_sigma_delta_dac.sv
// First-order sigma-delta modulator: carry-out of a level accumulator gives pulse density.
module sigma_delta_dac #(
   parameter int unsigned BW = 8
) (
   input  logic          clk_i,
   input  logic          rst_n_i,
   input  logic [BW-1:0] level_i,
   output logic          dens_o
);

   logic [BW-1:0] acc;
   logic [BW:0]   sum;

   assign sum = {1'b0, acc} + {1'b0, level_i};

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         acc    <= '0;
         dens_o <= 1'b0;
      end else begin
         {dens_o, acc} <= sum;
      end
   end

endmodule

// File: rtl/tone_envelope.sv
// Attack/decay/sustain envelope that gates a square wave through a sigma-delta density.
// Optional release phase on gate_i falling edge is enabled by defining ENV_RELEASE_EN.
module tone_envelope
   import tone_envelope_pkg::*;
#(
   parameter int unsigned        BW_LVL   = 8,
   parameter int unsigned        BW_PRE   = 16,
   parameter logic [BW_PRE-1:0]  TICK_DIV = 16'd9600
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              strb_i,
   input  logic              gate_i,
   input  logic              tone_i,
   input  logic [3:0]        attackStep_i,
   input  logic [3:0]        decayStep_i,
   input  logic [BW_LVL-1:0] sustainLvl_i,
   output logic              sound_o,
   output logic [BW_LVL-1:0] level_o,
   output logic [2:0]        state_o
);

   localparam logic [BW_LVL-1:0] LVL_MAX  = '1;
   localparam logic [BW_PRE-1:0] PRE_LAST = TICK_DIV - 1'b1;

   env_state_t        state;
   logic [BW_LVL-1:0] level;
   logic [BW_PRE-1:0] pre;
   logic              tick;
   logic              dens;
   logic [BW_LVL:0]   a_ext;
   logic [BW_LVL:0]   d_ext;
   logic [BW_LVL:0]   up;
   logic [BW_LVL:0]   dn;

   assign tick  = (pre == PRE_LAST);
   assign a_ext = (BW_LVL + 1)'(eff_step(attackStep_i));
   assign d_ext = (BW_LVL + 1)'(eff_step(decayStep_i));
   assign up    = {1'b0, level} + a_ext;
   assign dn    = {1'b0, level} - d_ext;

`ifdef ENV_RELEASE_EN
   logic gate_q;
   logic gate_fall;

   assign gate_fall = gate_q & ~gate_i;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) gate_q <= 1'b0;
      else          gate_q <= gate_i;
   end
`else
   logic unused_gate;
   assign unused_gate = gate_i;
`endif

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i)              pre <= '0;
      else if (strb_i || tick)   pre <= '0;
      else                       pre <= pre + 1'b1;
   end

   // Strobe retriggers without clearing level and pre-empts a coincident tick.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state <= IDLE;
         level <= '0;
      end else if (strb_i) begin
         state <= ATTACK;
`ifdef ENV_RELEASE_EN
      end else if (gate_fall && (state == ATTACK || state == DECAY || state == SUSTAIN)) begin
         state <= RELEASE;
`endif
      end else begin
         case (state)
            IDLE: level <= '0;
            ATTACK: if (tick) begin
               if (up >= {1'b0, LVL_MAX}) begin
                  level <= LVL_MAX;
                  state <= DECAY;
               end else begin
                  level <= up[BW_LVL-1:0];
               end
            end
            // Also covers sustainLvl_i >= level: dn is then below sustain.
            DECAY: if (tick) begin
               if (!dn[BW_LVL] && dn[BW_LVL-1:0] > sustainLvl_i) begin
                  level <= dn[BW_LVL-1:0];
               end else begin
                  level <= sustainLvl_i;
                  state <= SUSTAIN;
               end
            end
            SUSTAIN: level <= sustainLvl_i;
`ifdef ENV_RELEASE_EN
            RELEASE: if (tick) begin
               if (!dn[BW_LVL] && dn[BW_LVL-1:0] != '0) begin
                  level <= dn[BW_LVL-1:0];
               end else begin
                  level <= '0;
                  state <= IDLE;
               end
            end
`endif
            default: begin
               level <= '0;
               state <= IDLE;
            end
         endcase
      end
   end

   sigma_delta_dac #(.BW(BW_LVL)) u_dac (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .level_i (level),
      .dens_o  (dens)
   );

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) sound_o <= 1'b0;
      else          sound_o <= tone_i & dens;
   end

   assign level_o = level;
   assign state_o = state;

endmodule
